// File: rtl/sprite_renderer_if.sv
// Bus bundle for sprite_renderer: descriptor writes, pixel strobe, pixel-RAM port and video outputs.
interface sprite_renderer_if;
  logic        pix_en;
  logic        spr_we;
  logic [2:0]  spr_idx;
  logic [9:0]  spr_x;
  logic [9:0]  spr_y;
  logic [2:0]  spr_id;
  logic        spr_en;
  logic        bg_we;
  logic [3:0]  bg_color;
  logic [14:0] ram_addr;
  logic [3:0]  ram_q;
  logic [3:0]  pixel;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_start;

  modport slave (
    input  pix_en, spr_we, spr_idx, spr_x, spr_y, spr_id, spr_en, bg_we, bg_color, ram_q,
    output ram_addr, pixel, hsync, vsync, video_on, frame_start
  );

  modport master (
    output pix_en, spr_we, spr_idx, spr_x, spr_y, spr_id, spr_en, bg_we, bg_color, ram_q,
    input  ram_addr, pixel, hsync, vsync, video_on, frame_start
  );
endinterface

// File: rtl/sprite_renderer.sv
// Eight-slot 64x64 sprite renderer over a raster timing generator; shadow descriptor
// table is latched into the active table once per frame, two-stage pixel pipeline.
module sprite_renderer #(
  parameter int H_VIS    = 640,
  parameter int H_SYNC_S = 656,
  parameter int H_SYNC_E = 751,
  parameter int H_TOTAL  = 800,
  parameter int V_VIS    = 480,
  parameter int V_SYNC_S = 490,
  parameter int V_SYNC_E = 491,
  parameter int V_TOTAL  = 525
) (
  input  logic               clk,
  input  logic               rst_n,
  sprite_renderer_if.slave   bus
);

  localparam logic [9:0] HVIS  = 10'(H_VIS);
  localparam logic [9:0] HSS   = 10'(H_SYNC_S);
  localparam logic [9:0] HSE   = 10'(H_SYNC_E);
  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VVIS  = 10'(V_VIS);
  localparam logic [9:0] VSS   = 10'(V_SYNC_S);
  localparam logic [9:0] VSE   = 10'(V_SYNC_E);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);

  // Colour 0 from the sprite image is transparent and shows the background.
  function automatic logic [3:0] select_pixel(input logic vis, input logic hit,
                                              input logic [3:0] q, input logic [3:0] bg);
    if (!vis)
      return 4'd0;
    if (hit && (q != 4'd0))
      return q;
    return bg;
  endfunction

  logic [9:0]  hcnt_q, vcnt_q, hcnt_d, vcnt_d;
  logic [9:0]  sh_x_q [8];
  logic [9:0]  sh_y_q [8];
  logic [2:0]  sh_id_q [8];
  logic [7:0]  sh_en_q;
  logic [9:0]  act_x_q [8];
  logic [9:0]  act_y_q [8];
  logic [2:0]  act_id_q [8];
  logic [7:0]  act_en_q;
  logic [3:0]  bg_q;

  logic        vis_p1_q, hs_p1_q, vs_p1_q, hit_p1_q;
  logic [14:0] ram_addr_q;
  logic [3:0]  pixel_q;
  logic        hsync_q, vsync_q, video_on_q, frame_start_q;

  logic        h_wrap, frame_end;
  logic        vis_d, hs_d, vs_d, hit_d;
  logic [14:0] addr_d;
  logic [3:0]  pixel_d;
  logic [7:0]  slot_hit;
  logic [9:0]  dh [8];
  logic [9:0]  dv [8];

  always_comb begin
    h_wrap    = (hcnt_q == HT_M1);
    frame_end = h_wrap && (vcnt_q == VT_M1);
    hcnt_d    = h_wrap ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d    = vcnt_q;
    if (h_wrap)
      vcnt_d = (vcnt_q == VT_M1) ? 10'd0 : vcnt_q + 10'd1;
    vis_d = (hcnt_q < HVIS) && (vcnt_q < VVIS);
    hs_d  = (hcnt_q >= HSS) && (hcnt_q <= HSE);
    vs_d  = (vcnt_q >= VSS) && (vcnt_q <= VSE);
  end

  // Offsets are unsigned with no wrap, so sprites past the right/bottom edge clip.
  always_comb begin
    slot_hit = '0;
    hit_d    = 1'b0;
    addr_d   = ram_addr_q;
    for (int k = 0; k < 8; k++) begin
      dh[k] = hcnt_q - act_x_q[k];
      dv[k] = vcnt_q - act_y_q[k];
      slot_hit[k] = act_en_q[k] &&
                    (hcnt_q >= act_x_q[k]) && (dh[k][9:6] == 4'd0) &&
                    (vcnt_q >= act_y_q[k]) && (dv[k][9:6] == 4'd0);
    end
    for (int k = 7; k >= 0; k--) begin
      if (slot_hit[k]) begin
        hit_d  = 1'b1;
        addr_d = {act_id_q[k], dv[k][5:0], dh[k][5:0]};
      end
    end
    pixel_d = select_pixel(vis_p1_q, hit_p1_q, bus.ram_q, bg_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      sh_en_q       <= '0;
      act_en_q      <= '0;
      for (int k = 0; k < 8; k++) begin
        sh_x_q[k]   <= '0;
        sh_y_q[k]   <= '0;
        sh_id_q[k]  <= '0;
        act_x_q[k]  <= '0;
        act_y_q[k]  <= '0;
        act_id_q[k] <= '0;
      end
      bg_q          <= '0;
      vis_p1_q      <= 1'b0;
      hs_p1_q       <= 1'b0;
      vs_p1_q       <= 1'b0;
      hit_p1_q      <= 1'b0;
      ram_addr_q    <= '0;
      pixel_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (bus.spr_we) begin
        sh_x_q[bus.spr_idx]  <= bus.spr_x;
        sh_y_q[bus.spr_idx]  <= bus.spr_y;
        sh_id_q[bus.spr_idx] <= bus.spr_id;
        sh_en_q[bus.spr_idx] <= bus.spr_en;
      end
      if (bus.bg_we)
        bg_q <= bus.bg_color;
      if (bus.pix_en) begin
        hcnt_q     <= hcnt_d;
        vcnt_q     <= vcnt_d;
        // ---- stage 1: hit detection and RAM address ----
        vis_p1_q   <= vis_d;
        hs_p1_q    <= hs_d;
        vs_p1_q    <= vs_d;
        hit_p1_q   <= hit_d;
        ram_addr_q <= addr_d;
        // ---- stage 2: colour select and sync outputs ----
        pixel_q    <= pixel_d;
        hsync_q    <= ~hs_p1_q;
        vsync_q    <= ~vs_p1_q;
        video_on_q <= vis_p1_q;
        if (frame_end) begin
          for (int k = 0; k < 8; k++) begin
            act_x_q[k]  <= sh_x_q[k];
            act_y_q[k]  <= sh_y_q[k];
            act_id_q[k] <= sh_id_q[k];
          end
          act_en_q      <= sh_en_q;
          frame_start_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ram_addr    = ram_addr_q;
  assign bus.pixel       = pixel_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = video_on_q;
  assign bus.frame_start = frame_start_q;

endmodule
